// File: rtl/mm_ctrl_pkg.sv
// mm_ctrl_pkg: shared types and default sizes for the mm_systolic sequencer.
//   Holds the FSM state enum, the default array, element and address sizes,
//   and the packed operand vector type (ARRAY_N*DATA_W bits).
//   No ports; imported by the interface, the address generator and the top.

package mm_ctrl_pkg;

   localparam int ARRAY_N_DEF   = 8;
   localparam int DATA_W_DEF    = 8;
   localparam int ADDR_W_DEF    = 8;
   localparam int DRAIN_CYC_DEF = 16;

   typedef enum logic [2:0] {
      IDLE,
      FLUSH,
      ISSUE,
      TAIL,
      DRAIN,
      DONE
   } state_t;

   typedef logic [ARRAY_N_DEF*DATA_W_DEF-1:0] vec_t;

endpackage

// File: rtl/mm_systolic_ctrl_if.sv
// mm_systolic_ctrl_if: bundle between the sequencer, the scheduler, the two
// operand buffers and the systolic array.
//   scheduler side : start, k_len, a_base, b_base -> ctrl ; busy, done <- ctrl
//   A/B buffers    : *_rd_en, *_rd_addr <- ctrl ; *_rd_data -> ctrl (1-cycle latency)
//   array side     : row_bar, col_bar, bar_valid, flush <- ctrl
//   perf_cycles    : busy-cycle count of the current job, only when
//                    MM_CTRL_PERF_CNT_EN is defined.
// Modports: master = the sequencer, slave = its environment.

interface mm_systolic_ctrl_if
   import mm_ctrl_pkg::*;
#(
   parameter int ARRAY_N = ARRAY_N_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF
);

   logic                      start;
   logic [ADDR_W:0]           k_len;
   logic [ADDR_W-1:0]         a_base;
   logic [ADDR_W-1:0]         b_base;
   logic                      a_rd_en;
   logic [ADDR_W-1:0]         a_rd_addr;
   logic [ARRAY_N*DATA_W-1:0] a_rd_data;
   logic                      b_rd_en;
   logic [ADDR_W-1:0]         b_rd_addr;
   logic [ARRAY_N*DATA_W-1:0] b_rd_data;
   logic [ARRAY_N*DATA_W-1:0] row_bar;
   logic [ARRAY_N*DATA_W-1:0] col_bar;
   logic                      bar_valid;
   logic                      flush;
   logic                      busy;
   logic                      done;
`ifdef MM_CTRL_PERF_CNT_EN
   logic [31:0]               perf_cycles;
`endif

   modport master (
      input  start, k_len, a_base, b_base, a_rd_data, b_rd_data,
      output a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
      output row_bar, col_bar, bar_valid, flush, busy, done
`ifdef MM_CTRL_PERF_CNT_EN
      , output perf_cycles
`endif
   );

   modport slave (
      output start, k_len, a_base, b_base, a_rd_data, b_rd_data,
      input  a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
      input  row_bar, col_bar, bar_valid, flush, busy, done
`ifdef MM_CTRL_PERF_CNT_EN
      , input perf_cycles
`endif
   );

endinterface

// File: rtl/mm_ctrl_addr_gen.sv
// mm_ctrl_addr_gen: operand buffer read-address counter.
//   clk, rst_n : clock, synchronous active-low reset
//   load, base : load the job base address
//   step       : advance to the next address after a read beat
//   addr       : current read address, wraps modulo 2^ADDR_W

module mm_ctrl_addr_gen #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic [ADDR_W-1:0] base,
   output logic [ADDR_W-1:0] addr
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr <= '0;
      end else if (load) begin
         addr <= base;
      end else if (step) begin
         addr <= addr + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/mm_systolic_ctrl.sv
// mm_systolic_ctrl: sequencer for the ARRAY_N x ARRAY_N mm_systolic array.
//   clk    : clock
//   rst_n  : synchronous active-low reset; aborts any job without done
//   bus    : mm_systolic_ctrl_if.master (start/k_len/bases in, buffer reads,
//            row_bar/col_bar/bar_valid/flush to the array, busy/done out)
// Optional: define MM_CTRL_PERF_CNT_EN to add bus.perf_cycles, the busy-cycle
// count of the current job (cleared on accepted start, held after done).
// DRAIN_CYC must be at least 2*ARRAY_N so the array pipeline has emptied.
//
// state | meaning
// IDLE  | waiting for start
// FLUSH | one cycle, clears array accumulators
// ISSUE | k_len cycles of A/B buffer reads
// TAIL  | one cycle while the final read beat reaches the array
// DRAIN | array pipeline settle time
// DONE  | one cycle, completion
//
// All outputs are registered from the state, so they trail the state by one
// cycle; start is accepted only when the state is IDLE and busy has dropped,
// which also rejects a start in the cycle done is high.

module mm_systolic_ctrl
   import mm_ctrl_pkg::*;
#(
   parameter int ARRAY_N   = ARRAY_N_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   mm_systolic_ctrl_if.master  bus
);

   localparam int VEC_W   = ARRAY_N * DATA_W;
   localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);

   state_t               state;
   state_t               state_nxt;
   logic [ADDR_W:0]      beat_cnt;
   logic [DRAIN_W-1:0]   drain_cnt;
   logic                 accept;

   logic                 rd_en_q;
   logic                 bar_valid_q;
   logic                 flush_q;
   logic                 busy_q;
   logic                 done_q;

   assign accept = (state == IDLE) && !busy_q && bus.start;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = FLUSH;
         FLUSH:   state_nxt = (beat_cnt == '0) ? DRAIN : ISSUE;
         ISSUE:   if (beat_cnt == (ADDR_W+1)'(1)) state_nxt = TAIL;
         TAIL:    state_nxt = DRAIN;
         DRAIN:   if (drain_cnt == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Beat and drain timers are down-counters with a terminal count of zero.
   // An empty job skips ISSUE and TAIL, so its drain is one cycle longer to
   // keep the job length at k_len + DRAIN_CYC + 3 busy cycles.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         beat_cnt  <= '0;
         drain_cnt <= '0;
      end else begin
         if (accept) begin
            beat_cnt <= bus.k_len;
         end else if (state == ISSUE) begin
            beat_cnt <= beat_cnt - (ADDR_W+1)'(1);
         end

         if (state == FLUSH && beat_cnt == '0) begin
            drain_cnt <= DRAIN_W'(DRAIN_CYC);
         end else if (state == TAIL) begin
            drain_cnt <= DRAIN_W'(DRAIN_CYC - 1);
         end else if (state == DRAIN) begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_en_q     <= 1'b0;
         bar_valid_q <= 1'b0;
         flush_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         rd_en_q     <= (state == ISSUE);
         bar_valid_q <= rd_en_q;
         flush_q     <= (state == FLUSH);
         busy_q      <= (state != IDLE);
         done_q      <= (state == DONE);
      end
   end

   // Address advances after every issued beat, so the first beat reads base.
   mm_ctrl_addr_gen #(.ADDR_W(ADDR_W)) u_addr_a (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (accept),
      .step  (rd_en_q),
      .base  (bus.a_base),
      .addr  (bus.a_rd_addr)
   );

   mm_ctrl_addr_gen #(.ADDR_W(ADDR_W)) u_addr_b (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (accept),
      .step  (rd_en_q),
      .base  (bus.b_base),
      .addr  (bus.b_rd_addr)
   );

   assign bus.a_rd_en   = rd_en_q;
   assign bus.b_rd_en   = rd_en_q;
   assign bus.bar_valid = bar_valid_q;
   assign bus.flush     = flush_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

   // Read data arrives one cycle after rd_en, exactly when bar_valid is up.
   assign bus.row_bar = bar_valid_q ? bus.a_rd_data : {VEC_W{1'b0}};
   assign bus.col_bar = bar_valid_q ? bus.b_rd_data : {VEC_W{1'b0}};

`ifdef MM_CTRL_PERF_CNT_EN
   logic [31:0] perf_q;

   // Counts cycles in which busy will be high; stops once the FSM is back
   // in IDLE, so the total is final in the done cycle and held afterwards.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_q <= '0;
      end else if (accept) begin
         perf_q <= '0;
      end else if (state != IDLE) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign bus.perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_mm_systolic_ctrl.sv
module tb_mm_systolic_ctrl;
   import mm_ctrl_pkg::*;

   localparam int N  = 8;
   localparam int DW = 8;
   localparam int AW = 8;
   localparam int D  = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mm_systolic_ctrl_if #(.ARRAY_N(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

   mm_systolic_ctrl #(.ARRAY_N(N), .DATA_W(DW), .ADDR_W(AW), .DRAIN_CYC(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   vec_t mem_a [256];
   vec_t mem_b [256];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Operand buffers: 1-cycle read latency, junk on the bus when not reading.
   always @(posedge clk) begin
      bus.a_rd_data <= bus.a_rd_en ? mem_a[bus.a_rd_addr] : {$urandom, $urandom};
      bus.b_rd_data <= bus.b_rd_en ? mem_b[bus.b_rd_addr] : {$urandom, $urandom};
   end

   // Timeline reference for a job accepted at edge t, observed in cycle n
   // (after edge t+n): flush n=1, reads n=2..k+1 at base+n-2, beats
   // n=3..k+2 carrying buffer[base+n-3], done n=k+D+3, busy n=1..k+D+3.
   // poke1/poke2: cycles in which start is raised again (must be ignored).
   // abort_n: cycle in which rst_n is pulled low for one edge.
   task automatic run_job(input int k, input int ab, input int bb,
                          input int poke1, input int poke2, input int abort_n,
                          input string tag);
      int   last;
      bit   live;
      logic [5:0] exp_ctl, act_ctl;
      logic e_flush, e_busy, e_done, e_valid, e_rd;
      vec_t exp_row, exp_col;
      logic [AW-1:0] exp_aa, exp_ba;
      last = k + D + 6;
      @(negedge clk);
      bus.k_len  = (AW+1)'(k);
      bus.a_base = AW'(ab);
      bus.b_base = AW'(bb);
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.k_len  = (AW+1)'($urandom);
      bus.a_base = AW'($urandom);
      bus.b_base = AW'($urandom);
      for (int n = 1; n <= last; n++) begin
         @(negedge clk);
         live    = !(abort_n > 0 && n > abort_n);
         e_flush = live && (n == 1);
         e_busy  = live && (n >= 1) && (n <= k + D + 3);
         e_done  = live && (n == k + D + 3);
         e_valid = live && (n >= 3) && (n <= k + 2);
         e_rd    = live && (n >= 2) && (n <= k + 1);
         exp_ctl = {e_flush, e_busy, e_done, e_valid, e_rd, e_rd};
         act_ctl = {bus.flush, bus.busy, bus.done, bus.bar_valid, bus.a_rd_en, bus.b_rd_en};
         n_checks++;
         if (act_ctl !== exp_ctl)
            $display("FAIL %s ctl(flush,busy,done,valid,a_en,b_en) n=%0d got %b want %b",
                     tag, n, act_ctl, exp_ctl);
         else
            n_pass++;

         exp_row = e_valid ? mem_a[AW'(ab + n - 3)] : '0;
         exp_col = e_valid ? mem_b[AW'(bb + n - 3)] : '0;
         n_checks++;
         if ({bus.row_bar, bus.col_bar} !== {exp_row, exp_col})
            $display("FAIL %s bars n=%0d got row=%h col=%h want row=%h col=%h",
                     tag, n, bus.row_bar, bus.col_bar, exp_row, exp_col);
         else
            n_pass++;

         if (e_rd) begin
            exp_aa = AW'(ab + n - 2);
            exp_ba = AW'(bb + n - 2);
            n_checks++;
            if ({bus.a_rd_addr, bus.b_rd_addr} !== {exp_aa, exp_ba})
               $display("FAIL %s addr n=%0d got a=%0d b=%0d want a=%0d b=%0d",
                        tag, n, bus.a_rd_addr, bus.b_rd_addr, exp_aa, exp_ba);
            else
               n_pass++;
         end

`ifdef MM_CTRL_PERF_CNT_EN
         if (abort_n == 0 && n >= k + D + 3) begin
            n_checks++;
            if (bus.perf_cycles !== 32'(k + D + 3))
               $display("FAIL %s perf_cycles n=%0d got %0d want %0d",
                        tag, n, bus.perf_cycles, k + D + 3);
            else
               n_pass++;
         end
`endif

         bus.start = (n == poke1) || (n == poke2);
         rst_n     = !(n == abort_n);
      end
      bus.start = 1'b0;
      rst_n     = 1'b1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      bus.start = 1'b1;
      bus.k_len = (AW+1)'(5);
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus.flush, bus.busy, bus.done, bus.bar_valid, bus.a_rd_en, bus.b_rd_en,
           bus.a_rd_addr, bus.b_rd_addr, bus.row_bar, bus.col_bar} !== '0)
         $display("FAIL reset outputs got flush=%b busy=%b done=%b valid=%b en=%b%b want all 0",
                  bus.flush, bus.busy, bus.done, bus.bar_valid, bus.a_rd_en, bus.b_rd_en);
      else
         n_pass++;
`ifdef MM_CTRL_PERF_CNT_EN
      n_checks++;
      if (bus.perf_cycles !== 32'd0)
         $display("FAIL reset perf_cycles got %0d want 0", bus.perf_cycles);
      else
         n_pass++;
`endif
      bus.start = 1'b0;
      rst_n     = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_long_job();
      run_job(128, 0, 0, -1, -1, 0, "long_k128");
   endtask

   task automatic test_wrap();
      run_job(10, 250, int'($urandom_range(0, 255)), -1, -1, 0, "wrap_a250");
   endtask

   task automatic test_zero_len();
      run_job(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), -1, -1, 0, "k_zero");
   endtask

   task automatic test_ignored_starts();
      run_job(12, 7, 99, 4, 12 + D + 3, 0, "start_ignored");
   endtask

   task automatic test_reset_mid_issue();
      run_job(40, 30, 60, -1, -1, 10, "abort_mid_issue");
      run_job(7, 3, 200, -1, -1, 0, "after_abort");
   endtask

   task automatic test_max_len();
      run_job(256, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), -1, -1, 0, "k_max");
   endtask

   task automatic test_random();
      for (int j = 0; j < 6; j++)
         run_job(int'($urandom_range(0, 40)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), -1, -1, 0, "random");
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = {$urandom, $urandom};
         mem_b[i] = {$urandom, $urandom};
      end
      bus.start  = 1'b0;
      bus.k_len  = '0;
      bus.a_base = '0;
      bus.b_base = '0;
      test_reset();
      test_long_job();
      test_wrap();
      test_zero_len();
      test_ignored_starts();
      test_reset_mid_issue();
      test_max_len();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mm_systolic_ctrl.md
Name: mm_systolic_ctrl

Overview:
- Sequencer for the 8x8 mm_systolic array.
- On a start command it pulses flush to clear the accumulators, then streams k_len beats of A-column and B-row vectors from two operand buffers into row_bar/col_bar with bar_valid.
- After the last beat it waits a fixed drain time for the array pipeline to settle, then pulses done; the accumulated result in the array is then valid to read.
- Sits between the MHSA top-level scheduler (start/done) and the operand SRAMs plus mm_systolic.

Parameters:
- ARRAY_N, 8, array dimension; vectors per beat.
- DATA_W, 8, element width in bits.
- ADDR_W, 8, operand buffer address width.
- DRAIN_CYC, 16, cycles waited after the last valid beat before done; must be >= 2*ARRAY_N.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  command strobe; accepted only in IDLE.
- k_len  in  ADDR_W+1  beats per matmul; legal range 0..2^ADDR_W; sampled on an accepted start.
- a_base  in  ADDR_W  A buffer start address; sampled on an accepted start.
- b_base  in  ADDR_W  B buffer start address; sampled on an accepted start.
- a_rd_en  out  1  A buffer read enable.
- a_rd_addr  out  ADDR_W  A buffer read address.
- a_rd_data  in  ARRAY_N*DATA_W  A read data; fixed 1-cycle latency.
- b_rd_en  out  1  B buffer read enable.
- b_rd_addr  out  ADDR_W  B buffer read address.
- b_rd_data  in  ARRAY_N*DATA_W  B read data; fixed 1-cycle latency.
- row_bar  out  ARRAY_N*DATA_W  to array row input.
- col_bar  out  ARRAY_N*DATA_W  to array column input.
- bar_valid  out  1  beat valid, to array.
- flush  out  1  accumulator clear, to array.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: when rst_n is low at a clk edge, state goes to IDLE and all outputs are 0 after that edge; internal counters clear.
- Reset asserted mid-operation aborts the job; no done pulse is issued.
- FSM states: IDLE, FLUSH, ISSUE, TAIL, DRAIN, DONE.
- IDLE:
  - start=1 latches k_len, a_base, b_base and moves to FLUSH.
  - start in any other state is ignored and not queued.
- FLUSH: one cycle, flush=1.
  - Next state is ISSUE if k_len>0.
  - Next state is DRAIN if k_len==0; bar_valid never rises.
- ISSUE: lasts k_len cycles.
  - Beat i drives a_rd_en=b_rd_en=1, a_rd_addr=(a_base+i) mod 2^ADDR_W, b_rd_addr=(b_base+i) mod 2^ADDR_W.
  - Addresses wrap silently.
  - After the last beat, go to TAIL.
- bar_valid is the 1-cycle-delayed copy of a_rd_en.
- row_bar = a_rd_data and col_bar = b_rd_data while bar_valid=1; both are forced to 0 otherwise.
- The data path is combinational from the read data; the 1-cycle memory latency aligns it with bar_valid.
- TAIL: one cycle presenting the final beat, then DRAIN.
- DRAIN: exactly DRAIN_CYC cycles, then DONE.
- DONE: done=1 for one cycle with busy=1, then IDLE.
- A start asserted in the cycle done is high is ignored.
- Timeline for start accepted at edge t:
  - flush at t+1;
  - bar_valid high from t+3 to t+2+k_len;
  - done at t+3+k_len+DRAIN_CYC.
- Total busy cycles = k_len+DRAIN_CYC+3, counting each cycle in which busy=1.
- Beat counter is ADDR_W+1 bits wide, so k_len=2^ADDR_W is legal.

Optional Feature:
- Macro MM_CTRL_PERF_CNT_EN.
- With the macro defined:
  - adds output perf_cycles (32 bits), counting busy cycles of the current job;
  - the counter clears on an accepted start;
  - the value holds from done until the next accepted start;
  - reset value is 0.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package mm_ctrl_pkg holds:
  - the state enum (IDLE..DONE);
  - ARRAY_N/DATA_W/ADDR_W defaults;
  - the vector typedef (ARRAY_N*DATA_W logic).
- One sub-module is natural: mm_ctrl_addr_gen, the base+index wrap address counter, instantiated twice (A and B).

Test Plan:
- k_len=128, a_base=0, b_base=0, DRAIN_CYC=16, start at edge t:
  - flush at t+1;
  - 128 consecutive bar_valid beats starting t+3;
  - done at t+147; busy high for 147 cycles.
- Buffers preloaded with the row_data/col_data files, with mm_systolic attached:
  - res matches ref_result for all 64 entries at done.
- a_base=250, k_len=10:
  - a_rd_addr sequence is 250..255 then 0..3;
  - row_bar equals buffer contents in that order.
- k_len=0:
  - flush at t+1, no rd_en, no bar_valid;
  - done at t+3+DRAIN_CYC.
- start pulsed during ISSUE and again in the cycle done is high: both ignored, only one done.
- rst_n low for 1 cycle in mid-ISSUE:
  - all outputs 0 at the next edge, no done;
  - a new start afterwards completes normally.
- Perf counter (MM_CTRL_PERF_CNT_EN): perf_cycles=147 after the first scenario.
